i2c_cfg_sequencer: RTL and testbench
====================================

Name: i2c_cfg_sequencer

Overview:
- Generic sensor/codec register-configuration engine. It walks an external combinational config LUT and issues one register write per entry to the I2C master through a req/done handshake.
- Supports delay entries, per-entry retry on NACK, a power-up wait and restart.
- Sits between the per-sensor LUT modules (one {reg addr, reg data} word per index) and the I2C bit-level master.

Parameters:
- REG_AW, 16: register address width in bits (8 or 16).
- REG_DW, 16: register data width in bits (8 or 16).
- IDX_W, 8: LUT index and size width.
- UNIT_CYC, 50000: clk cycles per delay unit (1 ms at 50 MHz).
- DEF_DELAY, 200: delay units used when a delay entry's data field is 0.
- PWR_WAIT, 20: delay units waited after start before the first entry.
- MAX_RETRY, 3: extra attempts per entry after a NACK.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse; begins or restarts the sequence.
- lut_index  out  IDX_W  current LUT index.
- lut_data  in  REG_AW+REG_DW  {addr, data} for lut_index, valid the same cycle.
- lut_size  in  IDX_W  number of entries.
- i2c_req  out  1  transaction request, held until i2c_done.
- i2c_addr  out  REG_AW  register address.
- i2c_wdata  out  REG_DW  register data.
- i2c_rd  out  1  1 = read transaction (only with the optional feature).
- i2c_done  in  1  one-cycle pulse: transaction finished.
- i2c_nack  in  1  qualifies i2c_done: slave NACKed.
- i2c_rdata  in  REG_DW  read data, valid with i2c_done.
- busy  out  1  sequence in progress.
- cfg_done  out  1  level; all entries written successfully.
- cfg_err  out  1  level; aborted.
- err_index  out  IDX_W  index of the failing entry.

Behaviour:
- Reset values: all outputs 0, state IDLE, retry and delay counters 0.
- States: IDLE, PWAIT, FETCH, ISSUE, WAIT, DELAY, NEXT, DONE, ERR.
- IDLE/DONE/ERR + start:
  - clear cfg_done, cfg_err and lut_index; busy=1; go to PWAIT.
  - start in any other state is ignored.
- PWAIT: count PWR_WAIT*UNIT_CYC cycles, then go to FETCH.
- FETCH: one cycle; register lut_data.
  - addr field all-zero: delay entry, go to DELAY with count (data==0 ? DEF_DELAY : data)*UNIT_CYC.
  - otherwise: go to ISSUE.
- ISSUE: drive i2c_addr/i2c_wdata from the registered word, assert i2c_req, go to WAIT.
- WAIT: i2c_req stays high, outputs stable, until i2c_done.
  - i2c_done with i2c_nack=0: drop i2c_req the next cycle, go to NEXT.
  - i2c_done with i2c_nack=1 and retry<MAX_RETRY: retry++, re-enter ISSUE (i2c_req low for at least 1 cycle between attempts).
  - i2c_done with i2c_nack=1 and retries exhausted: err_index=lut_index, go to ERR.
- DELAY: down-counter to 0, then go to NEXT. Delay entries never touch the I2C bus.
- NEXT: clear retry.
  - lut_index==lut_size-1: go to DONE.
  - else: lut_index+1, go to FETCH.
- lut_size==0: PWAIT goes straight to DONE; no transactions issued.
- DONE: cfg_done=1, busy=0. ERR: cfg_err=1, busy=0. Both hold until the next start.
- Delay counter width: ceil(log2((2^REG_DW)*UNIT_CYC)); no overflow for the maximum data value.
- Reset asserted mid-transaction: i2c_req drops immediately (async); the master must tolerate an abandoned request.
- No backpressure beyond i2c_done; an i2c_done outside WAIT is ignored.

Optional Feature:
- Macro: I2C_CFG_IDCHK_EN.
- Defined:
  - entry 0 is a chip-ID check: ISSUE with i2c_rd=1, address from the entry.
  - on ACK, compare i2c_rdata to the entry's data field. Mismatch: err_index=0, go to ERR, no retry. Match: go to NEXT.
  - NACK follows the normal retry rules.
- Not defined: entry 0 is written like any other entry and i2c_rd is tied 0.

Test Plan:
- lut_size=4, entries {3000,0554},{301A,00D9},{0000,0000},{301A,10DC}, master always ACK; UNIT_CYC=4, PWR_WAIT=2, DEF_DELAY=3 -> 3 write reqs with exact addr/data, 12-cycle gap for the delay entry, cfg_done=1, busy=0.
- Entry 1 NACKed twice, then ACK, MAX_RETRY=3 -> 3 req pulses for index 1, sequence completes, cfg_err=0.
- Entry 2 NACKed 4 times -> 4 attempts, cfg_err=1, err_index=2, no further reqs; then start -> full rerun from index 0.
- Delay entry {0000,0005} -> 5*UNIT_CYC cycles with no req; lut_size=0 -> cfg_done after PWAIT, zero reqs.
- Reset pulsed while in WAIT -> i2c_req=0 and all outputs 0 in the same cycle; start is still needed to restart.
- With I2C_CFG_IDCHK_EN, rdata=0x0554 for entry {3000,0554} -> continues; rdata=0x0555 -> cfg_err=1, err_index=0.

Source files
------------

// File: rtl/i2c_cfg_sequencer.sv
// LUT-driven I2C register configuration sequencer with delay entries and NACK retry.
// Optional chip-ID read check on entry 0 when I2C_CFG_IDCHK_EN is defined.
`timescale 1ns/1ps
module i2c_cfg_sequencer #(
  parameter int REG_AW    = 16,
  parameter int REG_DW    = 16,
  parameter int IDX_W     = 8,
  parameter int UNIT_CYC  = 50000,
  parameter int DEF_DELAY = 200,
  parameter int PWR_WAIT  = 20,
  parameter int MAX_RETRY = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [IDX_W-1:0]         lut_index,
  input  logic [REG_AW+REG_DW-1:0] lut_data,
  input  logic [IDX_W-1:0]         lut_size,
  output logic                     i2c_req,
  output logic [REG_AW-1:0]        i2c_addr,
  output logic [REG_DW-1:0]        i2c_wdata,
  output logic                     i2c_rd,
  input  logic                     i2c_done,
  input  logic                     i2c_nack,
  input  logic [REG_DW-1:0]        i2c_rdata,
  output logic                     busy,
  output logic                     cfg_done,
  output logic                     cfg_err,
  output logic [IDX_W-1:0]         err_index
);

  localparam longint unsigned MAXD = (64'd1 << REG_DW) * longint'(UNIT_CYC);
  localparam longint unsigned PWRC = longint'(PWR_WAIT) * longint'(UNIT_CYC);
  localparam longint unsigned DEFC = longint'(DEF_DELAY) * longint'(UNIT_CYC);
  localparam int CW0 = $clog2(MAXD);
  localparam int CW1 = (CW0 > $clog2(PWRC + 1)) ? CW0 : $clog2(PWRC + 1);
  localparam int CW  = (CW1 > $clog2(DEFC + 1)) ? CW1 : $clog2(DEFC + 1);
  localparam int RW  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int WW  = REG_AW + REG_DW;

  localparam logic [CW-1:0] UNIT_C = CW'(UNIT_CYC);
  localparam logic [CW-1:0] PWR_C  = CW'(PWRC);
  localparam logic [RW-1:0] RMAX   = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE, S_PWAIT, S_FETCH, S_ISSUE, S_WAIT,
    S_DELAY, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [WW-1:0]       word_q;
  logic [RW-1:0]       retry_q;
  logic [CW-1:0]       cnt_q;
  logic                req_q;
  logic [REG_AW-1:0]   addr_q;
  logic [REG_DW-1:0]   wdata_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [IDX_W-1:0]    eidx_q;
  logic [REG_DW-1:0]   ldat;
  logic [CW-1:0]       dly_d;
  logic                is_dly;
  logic                last;

  always_comb begin
    ldat   = lut_data[REG_DW-1:0];
    is_dly = (lut_data[WW-1 -: REG_AW] == '0);
    dly_d  = ((ldat == '0) ? CW'(DEF_DELAY) : CW'(ldat)) * UNIT_C;
    last   = (idx_q == lut_size - IDX_W'(1));
  end

`ifdef I2C_CFG_IDCHK_EN
  logic rd_q;
  logic id_bad;
  assign i2c_rd = rd_q;
  assign id_bad = rd_q && (i2c_rdata != wdata_q);
`else
  logic unused_rdata;
  assign i2c_rd       = 1'b0;
  assign unused_rdata = ^i2c_rdata;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      retry_q <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      eidx_q  <= '0;
`ifdef I2C_CFG_IDCHK_EN
      rd_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            retry_q <= '0;
            cnt_q   <= PWR_C;
            state_q <= S_PWAIT;
          end
        end
        S_PWAIT: begin
          if (cnt_q <= CW'(1)) begin
            cnt_q <= '0;
            if (lut_size == '0) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              state_q <= S_FETCH;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_FETCH: begin
          word_q <= lut_data;
          if (is_dly) begin
            cnt_q   <= dly_d;
            state_q <= S_DELAY;
          end else begin
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          req_q   <= 1'b1;
          addr_q  <= word_q[WW-1 -: REG_AW];
          wdata_q <= word_q[REG_DW-1:0];
`ifdef I2C_CFG_IDCHK_EN
          rd_q    <= (idx_q == '0);
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (i2c_done) begin
            req_q <= 1'b0;
`ifdef I2C_CFG_IDCHK_EN
            rd_q  <= 1'b0;
`endif
            if (!i2c_nack) begin
`ifdef I2C_CFG_IDCHK_EN
              if (id_bad) begin
                eidx_q  <= '0;
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_ERR;
              end else begin
                state_q <= S_NEXT;
              end
`else
              state_q <= S_NEXT;
`endif
            end else if (retry_q < RMAX) begin
              retry_q <= retry_q + RW'(1);
              state_q <= S_ISSUE;
            end else begin
              eidx_q  <= idx_q;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_ERR;
            end
          end
        end
        S_DELAY: begin
          if (cnt_q <= CW'(1)) begin
            cnt_q   <= '0;
            state_q <= S_NEXT;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_NEXT: begin
          retry_q <= '0;
          if (last) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign lut_index = idx_q;
  assign i2c_req   = req_q;
  assign i2c_addr  = addr_q;
  assign i2c_wdata = wdata_q;
  assign busy      = busy_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign err_index = eidx_q;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: scripted I2C master, LUT memory and sequence model.
`timescale 1ns/1ps
module tb_i2c_cfg_sequencer;

  localparam int AW = 16, DW = 16, IW = 8;
  localparam int UNIT = 4, DEFD = 3, PWR = 2, MAXR = 3;

  logic          clk = 0;
  logic          rst = 1;
  logic          start = 0;
  logic [IW-1:0] lut_index;
  logic [31:0]   lut_data;
  logic [IW-1:0] lut_size = 0;
  logic          i2c_req;
  logic [AW-1:0] i2c_addr;
  logic [DW-1:0] i2c_wdata;
  logic          i2c_rd;
  logic          i2c_done = 0;
  logic          i2c_nack = 0;
  logic [DW-1:0] i2c_rdata;
  logic          busy, cfg_done, cfg_err;
  logic [IW-1:0] err_index;

  logic [31:0]   lut_mem [256];
  logic [DW-1:0] rd_flip = 0;

  int checks = 0;
  int failures = 0;

  bit        nack_q[$];
  int        lat = 1;
  int        wcnt = 0;
  bit        req_prev = 0;
  int        cyc = 0;
  int        log_a[$], log_d[$], log_rd[$], rise_t[$], done_t[$];
  int        exp_a[$], exp_d[$], exp_rd[$];
  bit        exp_err;
  int        exp_eidx;

  assign lut_data  = lut_mem[lut_index];
  assign i2c_rdata = lut_mem[0][15:0] ^ rd_flip;

  i2c_cfg_sequencer #(
    .REG_AW(AW), .REG_DW(DW), .IDX_W(IW), .UNIT_CYC(UNIT),
    .DEF_DELAY(DEFD), .PWR_WAIT(PWR), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .lut_index(lut_index), .lut_data(lut_data), .lut_size(lut_size),
    .i2c_req(i2c_req), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
    .i2c_rd(i2c_rd), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
    .i2c_rdata(i2c_rdata), .busy(busy), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .err_index(err_index)
  );

  always #5 clk = ~clk;

  // Master: answers each held request after `lat` cycles, NACK pattern from nack_q.
  always @(negedge clk) begin
    cyc++;
    i2c_done = 0;
    i2c_nack = 0;
    if (rst) begin
      wcnt = 0;
      req_prev = 0;
    end else begin
      if (i2c_req) begin
        if (!req_prev) rise_t.push_back(cyc);
        if (wcnt >= lat) begin
          i2c_done = 1;
          i2c_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
          log_a.push_back(int'(i2c_addr));
          log_d.push_back(int'(i2c_wdata));
          log_rd.push_back(int'(i2c_rd));
          done_t.push_back(cyc);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
      req_prev = i2c_req;
    end
  end

  task automatic clear_log();
    log_a.delete(); log_d.delete(); log_rd.delete();
    rise_t.delete(); done_t.delete();
  endtask

  // Expected transaction list from the LUT contents and the NACK script.
  task automatic build_model(input int size);
    int p = 0;
    exp_a.delete(); exp_d.delete(); exp_rd.delete();
    exp_err = 0;
    exp_eidx = 0;
    for (int i = 0; i < size && !exp_err; i++) begin
      int a = int'(lut_mem[i][31:16]);
      int d = int'(lut_mem[i][15:0]);
      int rd = 0;
`ifdef I2C_CFG_IDCHK_EN
      rd = (i == 0) ? 1 : 0;
`endif
      if (a == 0) continue;
      for (int r = 0; r <= MAXR; r++) begin
        bit nk = (p < nack_q.size()) ? nack_q[p] : 1'b0;
        p++;
        exp_a.push_back(a); exp_d.push_back(d); exp_rd.push_back(rd);
        if (!nk) begin
          if (rd == 1 && rd_flip != 0) begin
            exp_err = 1;
            exp_eidx = 0;
          end
          break;
        end
        if (r == MAXR) begin
          exp_err = 1;
          exp_eidx = i;
        end
      end
    end
  endtask

  task automatic run_seq(output bit to);
    int n = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    while (!(cfg_done || cfg_err) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    to = (n >= 20000);
    repeat (10) @(negedge clk);
  endtask

  task automatic load_basic();
    lut_mem[0] = 32'h3000_0554;
    lut_mem[1] = 32'h301A_00D9;
    lut_mem[2] = 32'h0000_0000;
    lut_mem[3] = 32'h301A_10DC;
    lut_size = 4;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({i2c_req, busy, cfg_done, cfg_err, lut_index, err_index,
         i2c_addr, i2c_wdata, i2c_rd} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b busy=%b done=%b err=%b idx=%0d eidx=%0d addr=%h data=%h expected all 0",
               i2c_req, busy, cfg_done, cfg_err, lut_index, err_index, i2c_addr, i2c_wdata);
    end
    rst = 0;
    repeat (20) @(negedge clk);
    checks++;
    if ({busy, i2c_req} !== 2'b00) begin
      failures++;
      $display("FAIL reset_idle got busy=%b req=%b expected 0 0", busy, i2c_req);
    end
  endtask

  task automatic test_basic();
    bit to;
    load_basic();
    lat = 2;
    nack_q.delete();
    clear_log();
    build_model(4);
    run_seq(to);
    checks++;
    if (to) begin failures++; $display("FAIL basic_timeout"); end
    checks++;
    if (log_a.size() != 3 || exp_a.size() != 3) begin
      failures++;
      $display("FAIL basic_count got=%0d expected=3", log_a.size());
    end
    for (int k = 0; k < exp_a.size() && k < log_a.size(); k++) begin
      checks++;
      if ({log_a[k], log_d[k], log_rd[k]} !== {exp_a[k], exp_d[k], exp_rd[k]}) begin
        failures++;
        $display("FAIL basic_txn%0d got %h/%h expected %h/%h", k, log_a[k], log_d[k], exp_a[k], exp_d[k]);
      end
    end
    // Consecutive writes are 4 cycles apart; a delay entry adds FETCH+NEXT+delay.
    if (rise_t.size() >= 3 && done_t.size() >= 2) begin
      checks++;
      if (rise_t[2] - done_t[1] != 4 + DEFD * UNIT + 2) begin
        failures++;
        $display("FAIL basic_delay_gap got=%0d expected=%0d", rise_t[2] - done_t[1], 4 + DEFD * UNIT + 2);
      end
    end
    checks++;
    if ({cfg_done, cfg_err, busy} !== 3'b100) begin
      failures++;
      $display("FAIL basic_status got done=%b err=%b busy=%b expected 1 0 0", cfg_done, cfg_err, busy);
    end
  endtask

  task automatic test_retry();
    bit to;
    load_basic();
    lat = 1;
    nack_q = '{0, 1, 1, 0, 0};
    clear_log();
    build_model(4);
    run_seq(to);
    checks++;
    if (to || log_a.size() != 5 || exp_a.size() != 5) begin
      failures++;
      $display("FAIL retry_count got=%0d expected=5 timeout=%b", log_a.size(), to);
    end
    for (int k = 0; k < exp_a.size() && k < log_a.size(); k++) begin
      checks++;
      if ({log_a[k], log_d[k]} !== {exp_a[k], exp_d[k]}) begin
        failures++;
        $display("FAIL retry_txn%0d got %h/%h expected %h/%h", k, log_a[k], log_d[k], exp_a[k], exp_d[k]);
      end
    end
    if (rise_t.size() >= 3 && done_t.size() >= 2) begin
      checks++;
      if (rise_t[2] - done_t[1] != 2) begin
        failures++;
        $display("FAIL retry_req_gap got=%0d expected=2", rise_t[2] - done_t[1]);
      end
    end
    checks++;
    if ({cfg_done, cfg_err} !== 2'b10) begin
      failures++;
      $display("FAIL retry_status got done=%b err=%b expected 1 0", cfg_done, cfg_err);
    end
  endtask

  task automatic test_error_restart();
    bit to;
    int n;
    lut_mem[0] = 32'h3000_0554;
    lut_mem[1] = 32'h301A_00D9;
    lut_mem[2] = 32'h3020_0011;
    lut_mem[3] = 32'h3030_0022;
    lut_size = 4;
    lat = 0;
    nack_q = '{0, 0, 1, 1, 1, 1};
    clear_log();
    build_model(4);
    run_seq(to);
    checks++;
    if (to || log_a.size() != 6 || exp_a.size() != 6) begin
      failures++;
      $display("FAIL err_count got=%0d expected=6 timeout=%b", log_a.size(), to);
    end
    checks++;
    if ({cfg_err, cfg_done, busy} !== 3'b100 || err_index !== IW'(exp_eidx) || exp_eidx != 2) begin
      failures++;
      $display("FAIL err_status got err=%b done=%b busy=%b eidx=%0d expected 1 0 0 2",
               cfg_err, cfg_done, busy, err_index);
    end
    n = log_a.size();
    repeat (40) @(negedge clk);
    checks++;
    if (log_a.size() != n || i2c_req !== 1'b0) begin
      failures++;
      $display("FAIL err_quiet got txns=%0d req=%b expected %0d 0", log_a.size(), i2c_req, n);
    end
    nack_q.delete();
    clear_log();
    build_model(4);
    run_seq(to);
    checks++;
    if (to || log_a.size() != 4 || log_a[0] != 32'h3000) begin
      failures++;
      $display("FAIL err_rerun got txns=%0d first=%h expected 4 3000", log_a.size(),
               (log_a.size() > 0) ? log_a[0] : -1);
    end
    checks++;
    if ({cfg_done, cfg_err} !== 2'b10) begin
      failures++;
      $display("FAIL err_rerun_status got done=%b err=%b expected 1 0", cfg_done, cfg_err);
    end
  endtask

  task automatic test_delay_and_empty();
    bit to;
    lut_mem[0] = 32'h3000_0001;
    lut_mem[1] = 32'h0000_0005;
    lut_mem[2] = 32'h3002_0002;
    lut_size = 3;
    lat = 1;
    nack_q.delete();
    clear_log();
    run_seq(to);
    checks++;
    if (to || log_a.size() != 2 || rise_t.size() < 2 || done_t.size() < 1) begin
      failures++;
      $display("FAIL delay_count got=%0d expected=2 timeout=%b", log_a.size(), to);
    end else begin
      checks++;
      if (rise_t[1] - done_t[0] != 4 + 5 * UNIT + 2) begin
        failures++;
        $display("FAIL delay_gap got=%0d expected=%0d", rise_t[1] - done_t[0], 4 + 5 * UNIT + 2);
      end
    end
    lut_size = 0;
    clear_log();
    run_seq(to);
    checks++;
    if (to || log_a.size() != 0 || {cfg_done, cfg_err, busy} !== 3'b100) begin
      failures++;
      $display("FAIL empty_lut got txns=%0d done=%b err=%b busy=%b expected 0 1 0 0",
               log_a.size(), cfg_done, cfg_err, busy);
    end
  endtask

  task automatic test_reset_midwait();
    bit to;
    int n = 0;
    load_basic();
    lat = 6;
    nack_q.delete();
    clear_log();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    while (!i2c_req && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (n >= 500) begin failures++; $display("FAIL midwait_no_req"); end
    #2 rst = 1;
    #1;
    checks++;
    if ({i2c_req, busy, cfg_done, cfg_err, lut_index, err_index, i2c_addr, i2c_wdata} !== '0) begin
      failures++;
      $display("FAIL midwait_reset got req=%b busy=%b idx=%0d addr=%h expected all 0",
               i2c_req, busy, lut_index, i2c_addr);
    end
    @(negedge clk); rst = 0;
    repeat (30) @(negedge clk);
    checks++;
    if ({busy, i2c_req} !== 2'b00) begin
      failures++;
      $display("FAIL midwait_stays_idle got busy=%b req=%b expected 0 0", busy, i2c_req);
    end
    lat = 1;
    clear_log();
    run_seq(to);
    checks++;
    if (to || log_a.size() != 3 || cfg_done !== 1'b1) begin
      failures++;
      $display("FAIL midwait_restart got txns=%0d done=%b expected 3 1", log_a.size(), cfg_done);
    end
  endtask

  task automatic test_random();
    bit to;
    for (int it = 0; it < 20; it++) begin
      int size = $urandom_range(1, 6);
      for (int i = 0; i < size; i++) begin
        if (i > 0 && $urandom_range(0, 3) == 0)
          lut_mem[i] = {16'h0000, 16'($urandom_range(0, 3))};
        else
          lut_mem[i] = {16'($urandom_range(1, 16'hFFFF)), 16'($urandom)};
      end
      lut_size = IW'(size);
      lat = $urandom_range(0, 3);
      nack_q.delete();
      for (int k = 0; k < 12; k++) nack_q.push_back($urandom_range(0, 2) == 0);
      clear_log();
      build_model(size);
      run_seq(to);
      checks++;
      if (to || log_a.size() != exp_a.size()) begin
        failures++;
        $display("FAIL rand%0d_count got=%0d expected=%0d timeout=%b", it, log_a.size(), exp_a.size(), to);
      end
      for (int k = 0; k < exp_a.size() && k < log_a.size(); k++) begin
        checks++;
        if ({log_a[k], log_d[k], log_rd[k]} !== {exp_a[k], exp_d[k], exp_rd[k]}) begin
          failures++;
          $display("FAIL rand%0d_txn%0d got %h/%h/%0d expected %h/%h/%0d", it, k,
                   log_a[k], log_d[k], log_rd[k], exp_a[k], exp_d[k], exp_rd[k]);
        end
      end
      checks++;
      if ({cfg_done, cfg_err} !== {!exp_err, exp_err} ||
          (exp_err && err_index !== IW'(exp_eidx))) begin
        failures++;
        $display("FAIL rand%0d_status got done=%b err=%b eidx=%0d expected %b %b %0d", it,
                 cfg_done, cfg_err, err_index, !exp_err, exp_err, exp_eidx);
      end
    end
  endtask

`ifdef I2C_CFG_IDCHK_EN
  task automatic test_idchk();
    bit to;
    load_basic();
    lat = 1;
    nack_q.delete();
    rd_flip = 16'h0001;
    clear_log();
    run_seq(to);
    checks++;
    if (to || {cfg_err, cfg_done} !== 2'b10 || err_index !== '0 || log_a.size() != 1 ||
        log_rd[0] != 1) begin
      failures++;
      $display("FAIL idchk_mismatch got err=%b eidx=%0d txns=%0d expected 1 0 1", cfg_err, err_index, log_a.size());
    end
    rd_flip = 0;
    clear_log();
    run_seq(to);
    checks++;
    if (to || {cfg_done, cfg_err} !== 2'b10 || log_a.size() != 3) begin
      failures++;
      $display("FAIL idchk_match got done=%b err=%b txns=%0d expected 1 0 3", cfg_done, cfg_err, log_a.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_retry();
    test_error_restart();
    test_delay_and_empty();
    test_reset_midwait();
    test_random();
`ifdef I2C_CFG_IDCHK_EN
    test_idchk();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
